// File: rtl/rf_wport_arbiter_if.sv
// Bundle of the pipeline, long-latency, hazard and RF write-port signals
// around rf_wport_arbiter. The pipeline/bench drives through master; the
// arbiter sits on slave.
interface rf_wport_arbiter_if;
   logic        wb_wr;
   logic [4:0]  wb_a3;
   logic [31:0] wb_wd;
   logic [31:0] wb_pc;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_a3;
   logic [31:0] lu_wd;
   logic [31:0] lu_pc;
   logic [4:0]  hz_a1;
   logic [4:0]  hz_a2;
   logic [4:0]  hz_a3;
   logic        hz_stall;
   logic        stall_req;
   logic        rf_wr;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;

   modport master (
      output wb_wr, wb_a3, wb_wd, wb_pc,
      output lu_valid, lu_a3, lu_wd, lu_pc,
      output hz_a1, hz_a2, hz_a3,
      input  lu_ready, hz_stall, stall_req,
      input  rf_wr, rf_a3, rf_wd
   );

   modport slave (
      input  wb_wr, wb_a3, wb_wd, wb_pc,
      input  lu_valid, lu_a3, lu_wd, lu_pc,
      input  hz_a1, hz_a2, hz_a3,
      output lu_ready, hz_stall, stall_req,
      output rf_wr, rf_a3, rf_wd
   );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter. The W stage has fixed priority and is
// written through combinationally; long-latency results queue in a DEPTH-entry
// FIFO and drain whenever the W stage leaves the port idle. Also provides a
// scoreboard match against queued destinations and a starvation stall request.
// Optional: define RF_WPORT_TRACE_EN to store PCs and print a write trace.
module rf_wport_arbiter #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input logic              clk,
   input logic              reset,
   rf_wport_arbiter_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             stall_q, stall_d;

   logic [4:0]       a3_mem [DEPTH];
   logic [31:0]      wd_mem [DEPTH];

   logic             a_active;
   logic             empty;
   logic             drain;
   logic             push;

   // r0 writes from the W stage are treated as idle so the FIFO can use the port.
   assign a_active     = bus.wb_wr && (bus.wb_a3 != 5'd0);
   assign empty        = (count_q == '0);
   assign drain        = !a_active && !empty;
   assign bus.lu_ready = (count_q < CW'(DEPTH));
   // Zero-destination results complete the handshake but are dropped.
   assign push         = bus.lu_valid && bus.lu_ready && (bus.lu_a3 != 5'd0);
   assign bus.stall_req = stall_q;

   // Next-state for pointers, count, valid bits and the starvation tracker.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      starve_d = starve_q;
      stall_d  = stall_q;
      if (drain) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + PW'(1);
      end
      if (push) begin
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      unique case ({push, drain})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (empty || drain) begin
         starve_d = '0;
      end else if (a_active && (starve_q < SW'(STARVE_LIMIT))) begin
         starve_d = starve_q + SW'(1);
      end
      if (empty || drain) begin
         stall_d = 1'b0;
      end else if (starve_d == SW'(STARVE_LIMIT)) begin
         stall_d = 1'b1;
      end
   end

   // Control state with asynchronous reset; queued entries are discarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   // Payload storage; only meaningful where the valid bit is set.
   always_ff @(posedge clk) begin
      if (push) begin
         a3_mem[wr_ptr_q] <= bus.lu_a3;
         wd_mem[wr_ptr_q] <= bus.lu_wd;
      end
   end

   // Write-port mux: W stage first, then FIFO head, else idle.
   always_comb begin
      bus.rf_wr = 1'b0;
      bus.rf_a3 = 5'd0;
      bus.rf_wd = 32'd0;
      if (a_active) begin
         bus.rf_wr = 1'b1;
         bus.rf_a3 = bus.wb_a3;
         bus.rf_wd = bus.wb_wd;
      end else if (drain) begin
         bus.rf_wr = 1'b1;
         bus.rf_a3 = a3_mem[rd_ptr_q];
         bus.rf_wd = wd_mem[rd_ptr_q];
      end
   end

   // Scoreboard: any queued destination (including the head being drained).
   always_comb begin
      bus.hz_stall = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (valid_q[i] &&
             (((bus.hz_a1 != 5'd0) && (a3_mem[i] == bus.hz_a1)) ||
              ((bus.hz_a2 != 5'd0) && (a3_mem[i] == bus.hz_a2)) ||
              ((bus.hz_a3 != 5'd0) && (a3_mem[i] == bus.hz_a3)))) begin
            bus.hz_stall = 1'b1;
         end
      end
   end

`ifdef RF_WPORT_TRACE_EN
   logic [31:0] pc_mem [DEPTH];

   // PC storage alongside each queued result.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q] <= bus.lu_pc;
      end
   end

   // Write trace for every non-r0 RF write.
   always_ff @(posedge clk) begin
      if (bus.rf_wr && (bus.rf_a3 != 5'd0)) begin
         $display("%h: $%d <= %h", a_active ? bus.wb_pc : pc_mem[rd_ptr_q], bus.rf_a3, bus.rf_wd);
      end
   end
`else
   wire unused_pc = ^{bus.wb_pc, bus.lu_pc};
`endif

endmodule
